checkout_tally: RTL and testbench

Sequential tally stage directly downstream of the checkout item classifier. Each key press is treated as one item scan. On each scan the block samples the classifier's `discount` and `stolen` flags together with the 3-bit UPC and the mark bit. It keeps saturating per-customer counts of items, discounted items and stolen items. On a stolen item it raises a latched alarm that blocks further scans until a clerk acknowledges it; the counts drive LEDR/HEX at the top level.

---
 rtl/checkout_tally.sv | 148 ++++++++++++++
 tb/tb_checkout_tally.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/checkout_tally.sv
// Per-customer scan tally behind the checkout classifier: saturating item, discount
// and stolen counts, plus a latched stolen-item alarm that blocks scanning until cleared.
module checkout_tally #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scan,
    input  logic             clear,
    input  logic [2:0]       upc,
    input  logic             mark,
    input  logic             discount,
    input  logic             stolen,
    output logic [WIDTH-1:0] item_cnt,
    output logic [WIDTH-1:0] disc_cnt,
    output logic [WIDTH-1:0] stolen_cnt,
    output logic             alarm,
    output logic [2:0]       alarm_upc,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COMMIT = 2'd1,
        ALARM  = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        if (v == {WIDTH{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + WIDTH'(1);
        end
    endfunction

    state_t           state_q, state_d;
    logic             scan_q;
    logic [2:0]       hold_upc_q, hold_upc_d;
    logic             hold_disc_q, hold_disc_d;
    logic             hold_stolen_q, hold_stolen_d;
    logic [WIDTH-1:0] item_cnt_q, item_cnt_d;
    logic [WIDTH-1:0] disc_cnt_q, disc_cnt_d;
    logic [WIDTH-1:0] stolen_cnt_q, stolen_cnt_d;
    logic             alarm_q, alarm_d;
    logic [2:0]       alarm_upc_q, alarm_upc_d;
    logic             busy_q, busy_d;
    logic             scan_ev_s;

    // The mark bit belongs to the classifier; it is carried here only so the item inputs stay together.
    logic mark_unused;
    assign mark_unused = mark;

    assign scan_ev_s = scan & ~scan_q;

    // Next-state and next-output computation for the tally FSM.
    always_comb begin
        state_d       = state_q;
        hold_upc_d    = hold_upc_q;
        hold_disc_d   = hold_disc_q;
        hold_stolen_d = hold_stolen_q;
        item_cnt_d    = item_cnt_q;
        disc_cnt_d    = disc_cnt_q;
        stolen_cnt_d  = stolen_cnt_q;
        alarm_d       = alarm_q;
        alarm_upc_d   = alarm_upc_q;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    item_cnt_d   = '0;
                    disc_cnt_d   = '0;
                    stolen_cnt_d = '0;
                end else if (scan_ev_s) begin
                    hold_upc_d    = upc;
                    hold_disc_d   = discount;
                    hold_stolen_d = stolen;
                    state_d       = COMMIT;
                end else begin
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                item_cnt_d = sat_inc(item_cnt_q);
                if (hold_disc_q) begin
                    disc_cnt_d = sat_inc(disc_cnt_q);
                end else begin
                    disc_cnt_d = disc_cnt_q;
                end
                if (hold_stolen_q) begin
                    stolen_cnt_d = sat_inc(stolen_cnt_q);
                    alarm_d      = 1'b1;
                    alarm_upc_d  = hold_upc_q;
                    state_d      = ALARM;
                end else begin
                    state_d = IDLE;
                end
            end
            ALARM: begin
                if (clear) begin
                    alarm_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = ALARM;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset overrides any pending commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            scan_q        <= 1'b1;
            hold_upc_q    <= 3'd0;
            hold_disc_q   <= 1'b0;
            hold_stolen_q <= 1'b0;
            item_cnt_q    <= '0;
            disc_cnt_q    <= '0;
            stolen_cnt_q  <= '0;
            alarm_q       <= 1'b0;
            alarm_upc_q   <= 3'd0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            scan_q        <= scan;
            hold_upc_q    <= hold_upc_d;
            hold_disc_q   <= hold_disc_d;
            hold_stolen_q <= hold_stolen_d;
            item_cnt_q    <= item_cnt_d;
            disc_cnt_q    <= disc_cnt_d;
            stolen_cnt_q  <= stolen_cnt_d;
            alarm_q       <= alarm_d;
            alarm_upc_q   <= alarm_upc_d;
            busy_q        <= busy_d;
        end
    end

    assign item_cnt   = item_cnt_q;
    assign disc_cnt   = disc_cnt_q;
    assign stolen_cnt = stolen_cnt_q;
    assign alarm      = alarm_q;
    assign alarm_upc  = alarm_upc_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_checkout_tally.sv
// Bench for checkout_tally: directed vector table, hand-written corner sequences,
// and random stimulus checked against a queue-based reference model.
module tb_checkout_tally;

    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;

    logic         clk;
    logic         reset;
    logic         scan;
    logic         clear;
    logic [2:0]   upc;
    logic         mark;
    logic         discount;
    logic         stolen;
    logic [W-1:0] item_cnt;
    logic [W-1:0] disc_cnt;
    logic [W-1:0] stolen_cnt;
    logic         alarm;
    logic [2:0]   alarm_upc;
    logic         busy;

    int total;
    int bad;

    checkout_tally #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .scan       (scan),
        .clear      (clear),
        .upc        (upc),
        .mark       (mark),
        .discount   (discount),
        .stolen     (stolen),
        .item_cnt   (item_cnt),
        .disc_cnt   (disc_cnt),
        .stolen_cnt (stolen_cnt),
        .alarm      (alarm),
        .alarm_upc  (alarm_upc),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r, s, c;
        logic [2:0] u;
        logic       d, t;
        int         ic, dc, sc, al, au, bz;
    } vec_t;

    typedef struct {
        int upc;
        bit disc;
        bit stl;
    } item_t;

    vec_t  vecs[$];
    item_t pend[$];
    int    m_ic, m_dc, m_sc, m_au;
    bit    m_al, m_prev;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int ic, input int dc, input int sc,
                         input int al, input int au, input int bz);
        total++;
        if (int'(item_cnt) != ic || int'(disc_cnt) != dc || int'(stolen_cnt) != sc ||
            int'(alarm) != al || int'(alarm_upc) != au || int'(busy) != bz) begin
            bad++;
            $display("FAIL %s t=%0t got item=%0d disc=%0d stolen=%0d alarm=%0d upc=%0d busy=%0d want item=%0d disc=%0d stolen=%0d alarm=%0d upc=%0d busy=%0d",
                     nm, $time, item_cnt, disc_cnt, stolen_cnt, alarm, alarm_upc, busy,
                     ic, dc, sc, al, au, bz);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic c, input logic [2:0] u,
                       input logic d, input logic t, input int ic, input int dc,
                       input int sc, input int al, input int au, input int bz);
        vec_t v;
        v.r = r; v.s = s; v.c = c; v.u = u; v.d = d; v.t = t;
        v.ic = ic; v.dc = dc; v.sc = sc; v.al = al; v.au = au; v.bz = bz;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic s, input logic c, input logic [2:0] u,
                         input logic d, input logic t);
        reset = r; scan = s; clear = c; upc = u; discount = d; stolen = t;
        mark = $urandom_range(0, 1) == 1;
    endtask

    // Reference: whole-item semantics; a captured scan is committed on the next edge.
    task automatic model_step();
        item_t p;
        if (reset) begin
            m_ic = 0; m_dc = 0; m_sc = 0; m_al = 1'b0; m_au = 0;
            pend.delete();
            m_prev = 1'b1;
        end else begin
            if (pend.size() > 0) begin
                p = pend.pop_front();
                m_ic = (m_ic < MAX) ? m_ic + 1 : MAX;
                if (p.disc) m_dc = (m_dc < MAX) ? m_dc + 1 : MAX;
                if (p.stl) begin
                    m_sc = (m_sc < MAX) ? m_sc + 1 : MAX;
                    m_al = 1'b1;
                    m_au = p.upc;
                end
            end else if (m_al) begin
                if (clear) m_al = 1'b0;
            end else if (clear) begin
                m_ic = 0; m_dc = 0; m_sc = 0;
            end else if (scan && !m_prev) begin
                p.upc = int'(upc); p.disc = discount; p.stl = stolen;
                pend.push_back(p);
            end
            m_prev = scan;
        end
    endtask

    task automatic scan_once(input logic [2:0] u, input logic d, input logic t);
        drive(1'b0, 1'b1, 1'b0, u, d, t);
        tick();
        drive(1'b0, 1'b0, 1'b0, u, d, t);
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

        // r  s  c  upc   d  t   ic dc sc al au bz
        add(1, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 0, 3'd0, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 3'd2, 1, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 3'd0, 0, 0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 3'd0, 0, 0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 3'd0, 0, 0, 1, 1, 0, 0, 0, 0);
        add(0, 1, 0, 3'd3, 1, 0, 1, 1, 0, 0, 0, 1);
        add(0, 0, 0, 3'd0, 0, 1, 2, 2, 0, 0, 0, 0);
        add(0, 0, 0, 3'd0, 0, 0, 2, 2, 0, 0, 0, 0);
        add(0, 0, 0, 3'd0, 0, 0, 2, 2, 0, 0, 0, 0);
        add(0, 1, 0, 3'd4, 1, 0, 2, 2, 0, 0, 0, 1);
        add(0, 0, 0, 3'd0, 0, 0, 3, 3, 0, 0, 0, 0);
        add(0, 0, 0, 3'd0, 0, 0, 3, 3, 0, 0, 0, 0);
        add(0, 1, 0, 3'd5, 0, 1, 3, 3, 0, 0, 0, 1);
        add(0, 0, 0, 3'd0, 0, 0, 4, 3, 1, 1, 5, 1);
        add(0, 1, 0, 3'd2, 1, 1, 4, 3, 1, 1, 5, 1);
        add(0, 0, 0, 3'd0, 0, 0, 4, 3, 1, 1, 5, 1);
        add(0, 1, 0, 3'd6, 1, 1, 4, 3, 1, 1, 5, 1);
        add(0, 0, 1, 3'd0, 0, 0, 4, 3, 1, 0, 5, 0);
        add(0, 0, 0, 3'd0, 0, 0, 4, 3, 1, 0, 5, 0);
        add(0, 0, 1, 3'd0, 0, 0, 0, 0, 0, 0, 5, 0);
        add(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 5, 0);
        add(0, 1, 0, 3'd1, 0, 0, 0, 0, 0, 0, 5, 1);
        add(0, 0, 0, 3'd0, 0, 0, 1, 0, 0, 0, 5, 0);
        add(0, 1, 0, 3'd1, 0, 0, 1, 0, 0, 0, 5, 1);
        add(0, 0, 0, 3'd0, 0, 0, 2, 0, 0, 0, 5, 0);
        add(0, 1, 1, 3'd7, 1, 1, 0, 0, 0, 0, 5, 0);
        add(0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 5, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].r, vecs[i].s, vecs[i].c, vecs[i].u, vecs[i].d, vecs[i].t);
            tick();
            check($sformatf("vec%0d", i), vecs[i].ic, vecs[i].dc, vecs[i].sc,
                  vecs[i].al, vecs[i].au, vecs[i].bz);
        end

        // Saturation: 17 discount scans two cycles apart, then a stolen one.
        drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 17; i++) scan_once(3'd1, 1'b1, 1'b0);
        check("sat_items", MAX, MAX, 0, 0, 0, 0);
        scan_once(3'd6, 1'b0, 1'b1);
        check("sat_stolen", MAX, MAX, 1, 1, 6, 1);
        drive(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        tick();
        check("ack_retain", MAX, MAX, 1, 0, 6, 0);

        // Reset landing on the commit edge of a stolen scan.
        drive(1'b0, 1'b1, 1'b0, 3'd7, 1'b1, 1'b1);
        tick();
        check("pre_commit", MAX, MAX, 1, 0, 6, 1);
        drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        check("reset_commit", 0, 0, 0, 0, 0, 0);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        tick();
        check("post_reset", 0, 0, 0, 0, 0, 0);

        // Random phase against the reference model.
        drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        model_step();
        tick();
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) != 0),
                  ($urandom_range(0, 11) == 0), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 5) == 0));
            model_step();
            tick();
            check("rand", m_ic, m_dc, m_sc, int'(m_al), m_au, int'((pend.size() > 0) || m_al));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
